// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer between the IF stage and a
// word-addressed instruction memory. Owns the fetch PC, keeps at most one read
// outstanding over a req/ack handshake, buffers returned words in a small
// prefetch queue and presents {instr, pc} to IF/ID.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        instr_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
`endif
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | no request pending; waits for queue room (or a redirect)
  // REQ   | request pending at r_addr; ack pushes the word into the queue
  // DRAIN | stale request pending after a redirect; ack data is dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  state_t          r_state;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [31:0]     r_fetch_pc;

  logic [31:0]     r_q_instr [QDEPTH];
  logic [31:0]     r_q_pc    [QDEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic            w_ack;
  logic            w_pop;
  logic            w_push;
  logic            w_can_issue;
  logic [CW-1:0]   w_count_nxt;
  logic [31:0]     w_pc_inc;
  logic [31:0]     w_redir_pc;
  logic [31:0]     w_drain_tgt;
  logic            w_unused_redir_lsb;

  assign mem_req_o     = r_req;
  assign mem_addr_o    = r_addr;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = instr_valid_o ? r_q_instr[r_rd_ptr] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? r_q_pc[r_rd_ptr]    : 32'h0;

  // An ack only counts while a request is actually on the bus.
  assign w_ack  = mem_ack_i & r_req;
  // Redirect wins over both queue operations: a pop that cycle is void and
  // any returning data belongs to the abandoned path.
  assign w_pop  = instr_valid_o & instr_ready_i & ~redirect_i;
  assign w_push = w_ack & (r_state == S_REQ) & ~redirect_i;

  assign w_pc_inc    = r_fetch_pc + 32'd4;
  assign w_redir_pc  = {redirect_pc_i[31:2], 2'b00};
  assign w_drain_tgt = redirect_i ? w_redir_pc : r_fetch_pc;
  assign w_unused_redir_lsb = ^redirect_pc_i[1:0];

  // Queue occupancy after this edge, used by the issue rule.
  always_comb begin
    w_count_nxt = r_count;
    if (redirect_i) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Every state transition out of this edge leaves no request outstanding
  // before deciding whether to raise a new one, so a new request needs one
  // free slot beyond the next-cycle occupancy.
  assign w_can_issue = (w_count_nxt < CW'(QDEPTH));

  // Fetch FSM with registered request, address and fetch PC.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
          end
          if (w_can_issue) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= redirect_i ? w_redir_pc : r_fetch_pc;
          end
        end

        S_REQ: begin
          if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
            if (w_ack) begin
              // Old request retired this cycle; restart straight away.
              if (w_can_issue) begin
                r_addr <= w_redir_pc;
              end else begin
                r_state <= S_IDLE;
                r_req   <= 1'b0;
              end
            end else begin
              // Old request must still complete at its original address.
              r_state <= S_DRAIN;
            end
          end else if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_can_issue) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end

        S_DRAIN: begin
          if (w_ack) begin
            r_fetch_pc <= w_drain_tgt;
            if (w_can_issue) begin
              r_state <= S_REQ;
              r_addr  <= w_drain_tgt;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end else if (redirect_i) begin
            r_fetch_pc <= w_redir_pc;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Queue storage; contents are only observed through the valid-masked head.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= mem_rdata_i;
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  assign stall_cycles_o = r_stall_cycles;
  assign flush_count_o  = r_flush_count;

  // Saturating counters: head held by a stall, and accepted redirects.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cycles <= 32'h0;
      r_flush_count  <= 32'h0;
    end else begin
      if (instr_valid_o && !instr_ready_i && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (redirect_i && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a behavioural memory with
// configurable ack latency, a scoreboard of expected {instr, pc} heads, and
// directed scenarios for stall, redirect, drain, wrap and reset.
module tb_imem_fetch_ctrl;

  localparam int          QDEPTH = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        instr_ready_i = 1'b1;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;
`endif

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_ready_i (instr_ready_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles_o(stall_cycles_o),
    .flush_count_o (flush_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] ack_log[$];
  logic [31:0] drop_log[$];

  int          n_chk  = 0;
  int          n_pass = 0;
  int          lat    = 0;
  int          wait_cnt = 0;
  logic        cfg_ready = 1'b1;
  logic        cfg_spur  = 1'b0;
  logic [31:0] exp_pc  = 32'h0;
  logic        discard = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          m_stall = 0;
  int          m_flush = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp_v, $time);
  endtask

  function automatic logic [31:0] logq(input int i);
    if (i < ack_log.size()) return ack_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Negedge: drive memory response and default inputs for the coming edge.
  task automatic cyc_begin();
    @(negedge clk_i);
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = cfg_ready;
    if (mem_req_o) begin
      if (wait_cnt >= lat) begin
        mem_ack_i = 1'b1;
        wait_cnt  = 0;
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack_i = cfg_spur;
      wait_cnt  = 0;
    end
    mem_rdata_i = mem_addr_o ^ KEY;
  endtask

  // Same time slot: check outputs, then model what the coming edge does.
  task automatic cyc_end();
    logic ack_eff;
    logic pop;
    ack_eff = mem_ack_i && mem_req_o;
    check_eq("valid", 32'(instr_valid_o), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check_eq("head_instr", instr_o, sb[0].instr);
      check_eq("head_pc", instr_pc_o, sb[0].pc);
    end else begin
      check_eq("empty_instr", instr_o, 32'h0);
      check_eq("empty_pc", instr_pc_o, 32'h0);
    end
    check_eq("no_overflow", 32'((sb.size() + (mem_req_o ? 1 : 0)) <= QDEPTH), 32'h1);
    if (prev_req && !prev_ack) begin
      check_eq("req_hold", 32'(mem_req_o), 32'h1);
      check_eq("addr_hold", mem_addr_o, prev_addr);
    end
    if (instr_valid_o && !instr_ready_i) m_stall++;
    if (redirect_i) begin
      m_flush++;
      sb.delete();
      exp_pc  = {redirect_pc_i[31:2], 2'b00};
      discard = mem_req_o && !mem_ack_i;
    end else begin
      pop = instr_valid_o && instr_ready_i;
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (ack_eff) begin
        if (discard) begin
          discard = 1'b0;
          drop_log.push_back(mem_addr_o);
        end else begin
          check_eq("ack_addr", mem_addr_o, exp_pc);
          sb.push_back('{instr: exp_pc ^ KEY, pc: exp_pc});
          ack_log.push_back(exp_pc);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    prev_req  = mem_req_o;
    prev_ack  = ack_eff;
    prev_addr = mem_addr_o;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      cyc_end();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_eq("rst_req", 32'(mem_req_o), 32'h0);
    check_eq("rst_addr", mem_addr_o, 32'h0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'h0);
    check_eq("rst_instr", instr_o, 32'h0);
    check_eq("rst_pc", instr_pc_o, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_stall_cnt", stall_cycles_o, 32'h0);
    check_eq("rst_flush_cnt", flush_count_o, 32'h0);
`endif
    mem_ack_i = 1'b0;
    redirect_i = 1'b0;
    instr_ready_i = 1'b1;
    wait_cnt = 0;
    sb.delete();
    ack_log.delete();
    drop_log.delete();
    exp_pc = 32'h0;
    discard = 1'b0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    m_stall = 0;
    m_flush = 0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    int idx;
    int n;

    // Zero-wait stream with ready high.
    lat = 0; cfg_ready = 1'b1; cfg_spur = 1'b0;
    do_reset();
    cyc_begin();
    check_eq("first_req", 32'(mem_req_o), 32'h1);
    check_eq("first_addr", mem_addr_o, 32'h0);
    cyc_end();
    cycles(6);
    check_eq("seq_addr0", logq(0), 32'h0);
    check_eq("seq_addr1", logq(1), 32'h4);
    check_eq("seq_addr2", logq(2), 32'h8);
    check_eq("seq_addr3", logq(3), 32'hC);

    // Stall with head at pc 0x8; spurious acks while idle must be ignored.
    do_reset();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (instr_valid_o && instr_pc_o == 32'h8) begin
        instr_ready_i = 1'b0;
        hit = 1;
      end
      cyc_end();
    end
    check_eq("stall_found", 32'(hit), 32'h1);
    cfg_ready = 1'b0; cfg_spur = 1'b1;
    cycles(5);
    check_eq("stall_req_low", 32'(mem_req_o), 32'h0);
    check_eq("stall_head_pc", instr_pc_o, 32'h8);
    check_eq("stall_acks", 32'(ack_log.size()), 32'd4);
    cfg_ready = 1'b1; cfg_spur = 1'b0;
    cyc_begin();
    check_eq("resume_head0", instr_pc_o, 32'h8);
    cyc_end();
    cyc_begin();
    check_eq("resume_head1", instr_pc_o, 32'hC);
    cyc_end();
    cycles(4);
    check_eq("resume_fetch", logq(4), 32'h10);

    // Reset abandons an outstanding request.
    lat = 5;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      cyc_begin();
      cyc_end();
      if (mem_req_o && wait_cnt >= 2) hit = 1;
    end
    check_eq("pre_rst_req", 32'(mem_req_o), 32'h1);
    do_reset();

    // 3-wait memory, redirect to 0x41 in the second wait cycle of 0x4.
    lat = 3;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc_begin();
      if (mem_req_o && mem_addr_o == 32'h4 && !mem_ack_i && wait_cnt == 2) begin
        redirect_i = 1'b1;
        redirect_pc_i = 32'h41;
        hit = 1;
      end
      cyc_end();
    end
    check_eq("drain_found", 32'(hit), 32'h1);
    for (int i = 0; i < 20 && drop_log.size() == 0; i++) cycles(1);
    check_eq("drain_drop_addr", (drop_log.size() != 0) ? drop_log[0] : 32'hDEAD_BEEF, 32'h4);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (instr_valid_o) begin
        check_eq("drain_first_pc", instr_pc_o, 32'h40);
        check_eq("drain_first_instr", instr_o, 32'h40 ^ KEY);
        hit = 1;
      end
      cyc_end();
    end
    check_eq("drain_head_seen", 32'(hit), 32'h1);
    check_eq("drain_ack_after", logq(1), 32'h40);

    // Retarget while draining: the last redirect wins.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (mem_req_o && !mem_ack_i && wait_cnt == 1) begin
        redirect_i = 1'b1;
        redirect_pc_i = 32'h300;
        hit = 1;
      end
      cyc_end();
    end
    check_eq("retarget_found", 32'(hit), 32'h1);
    cyc_begin();
    check_eq("retarget_ack_pending", 32'(mem_ack_i), 32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h205;
    cyc_end();
    idx = ack_log.size();
    cycles(12);
    check_eq("retarget_addr", logq(idx), 32'h204);
    check_eq("retarget_drops", 32'(drop_log.size()), 32'd2);

    // Redirect coincident with ack of 0x8 while a pop is attempted.
    lat = 0;
    do_reset();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (mem_req_o && mem_ack_i && mem_addr_o == 32'h8) begin
        check_eq("coinc_pop_valid", 32'(instr_valid_o && instr_ready_i), 32'h1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        hit = 1;
      end
      cyc_end();
    end
    check_eq("coinc_found", 32'(hit), 32'h1);
    cyc_begin();
    check_eq("coinc_valid", 32'(instr_valid_o), 32'h0);
    check_eq("coinc_instr", instr_o, 32'h0);
    check_eq("coinc_req", 32'(mem_req_o), 32'h1);
    check_eq("coinc_addr", mem_addr_o, 32'h100);
    cyc_end();
    cycles(3);

    // PC wrap; low redirect bits are ignored.
    cyc_begin();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    cyc_end();
    idx = ack_log.size();
    cycles(6);
    check_eq("wrap_addr0", logq(idx), 32'hFFFF_FFFC);
    check_eq("wrap_addr1", logq(idx + 1), 32'h0);
    check_eq("wrap_addr2", logq(idx + 2), 32'h4);

    // Random mix of stalls, latencies and redirects against the scoreboard.
    for (int s = 0; s < 6; s++) begin
      lat = $urandom_range(0, 2);
      for (int i = 0; i < 40; i++) begin
        cyc_begin();
        instr_ready_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          redirect_i = 1'b1;
          redirect_pc_i = $urandom;
        end
        cyc_end();
      end
    end

`ifdef FETCH_PERF_CNT_EN
    // Exactly 5 stall cycles and 3 redirects after a fresh reset.
    lat = 0; cfg_ready = 1'b1;
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      cyc_begin();
      if (instr_valid_o) begin
        instr_ready_i = 1'b0;
        n++;
      end
      cyc_end();
    end
    for (int r = 0; r < 3; r++) begin
      cyc_begin();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h500 + 32'(r * 16);
      cyc_end();
      cycles(1);
    end
    cyc_begin();
    check_eq("perf_stall", stall_cycles_o, 32'd5);
    check_eq("perf_flush", flush_count_o, 32'd3);
    check_eq("perf_stall_model", stall_cycles_o, 32'(m_stall));
    cyc_end();
    do_reset();
`else
    n = 0;
`endif

    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
